// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, byte-lane masks.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_LD_WAIT,
    S_ST,
    S_RMW_RD,
    S_RMW_MERGE,
    S_RMW_WR,
    S_ERR
  } lsu_state_e;

  localparam logic [3:0] LANES_BYTE = 4'b0001;
  localparam logic [3:0] LANES_HALF = 4'b0011;
  localparam logic [3:0] LANES_WORD = 4'b1111;

  // The spare encoding 2'b11 behaves as a word access.
  function automatic lsu_size_e norm_size(input logic [1:0] raw);
    return (raw == 2'b11) ? SZ_WORD : lsu_size_e'(raw);
  endfunction

  function automatic logic [3:0] lane_mask(input lsu_size_e size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return LANES_BYTE << a;
      SZ_HALF: return LANES_HALF << a;
      default: return LANES_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] a);
    case (size)
      SZ_HALF: return a[0];
      SZ_WORD: return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  lanes,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] repl;
  logic [31:0] byte_en;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Store data is replicated into every lane; the lane mask picks which ones land.
  always_comb begin
    repl    = (size == SZ_BYTE) ? {4{wdata[7:0]}} : {2{wdata}};
    byte_en = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    merged  = (rdata & ~byte_en) | (repl & byte_en);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: CPU request to single-port word memory, with read-modify-write for sub-word stores.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests respond with resp_err instead of being truncated.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data
);

  // state       | meaning
  // S_IDLE      | ready for a request
  // S_LD        | memread issued for a load
  // S_LD_WAIT   | read data valid, extract and respond
  // S_ST        | full-word memwrite
  // S_RMW_RD    | memread of the word under a sub-word store
  // S_RMW_MERGE | register read word with store lanes replaced
  // S_RMW_WR    | memwrite of merged word
  // S_ERR       | misaligned request, respond with error

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  lsu_size_e         size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;

  lsu_size_e         req_size_n;
  logic [ADDR_W-1:0] req_addr_aligned;
  logic              accept;
  logic              trap_req;
  logic              resp_done;
  logic [3:0]        lanes;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign req_size_n = norm_size(req_size);
  assign req_ready  = (state_q == S_IDLE);
  assign accept     = req_valid && req_ready;

  always_comb begin
    req_addr_aligned = req_addr;
    case (req_size_n)
      SZ_HALF: req_addr_aligned[0]   = 1'b0;
      SZ_WORD: req_addr_aligned[1:0] = 2'b00;
      default: req_addr_aligned      = req_addr;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_req = is_misaligned(req_size_n, req_addr[1:0]);
`else
  assign trap_req = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (trap_req)                 state_d = S_ERR;
          else if (!req_write)          state_d = S_LD;
          else if (req_size_n == SZ_WORD) state_d = S_ST;
          else                          state_d = S_RMW_RD;
        end
      end
      S_LD: begin
        mem_memread = 1'b1;
        state_d     = S_LD_WAIT;
      end
      S_LD_WAIT:   state_d = S_IDLE;
      S_ST: begin
        mem_memwrite = 1'b1;
        state_d      = S_IDLE;
      end
      S_RMW_RD: begin
        mem_memread = 1'b1;
        state_d     = S_RMW_MERGE;
      end
      S_RMW_MERGE: state_d = S_RMW_WR;
      S_RMW_WR: begin
        mem_memwrite = 1'b1;
        state_d      = S_IDLE;
      end
      S_ERR:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign resp_done = (state_q == S_LD_WAIT) || (state_q == S_ST) ||
                     (state_q == S_RMW_WR)  || (state_q == S_ERR);

  assign lanes    = lane_mask(size_q, addr_q[1:0]);
  assign mem_addr = 32'(addr_q >> 2);

  // Lane mask and write data stay quiet outside an actual memory access.
  always_comb begin
    mem_sign_mask  = (mem_memread || mem_memwrite) ? lanes : 4'b0000;
    mem_write_data = 32'h0;
    if (state_q == S_ST)     mem_write_data = wdata_q;
    if (state_q == S_RMW_WR) mem_write_data = merge_q;
  end

  lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .lanes       (lanes),
    .rdata       (mem_read_data),
    .wdata       (wdata_q[15:0]),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr_aligned;
        size_q  <= req_size_n;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
      if (state_q == S_RMW_MERGE) merge_q <= merged;
      resp_valid_q <= resp_done;
      if (state_q == S_LD_WAIT) resp_rdata_q <= load_data;
      else if (resp_done)       resp_rdata_q <= 32'h0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic resp_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_err_q <= 1'b0;
    else        resp_err_q <= (state_q == S_ERR);
  end
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic against a byte-level model.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] bus_mem [16];
  logic [31:0] ref_mem [16];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_idx = 4'h0;
  logic [31:0] bd_data = 32'h0;

  int          n_rd, n_wr;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_mask;
  logic [31:0] last_resp;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
  );

  // Registered single-port memory; writes take the whole word so a bad merge is visible.
  always @(posedge clk) begin
    if (mem_memread) mem_read_data <= bus_mem[mem_addr[3:0]];
    if (mem_memwrite) bus_mem[mem_addr[3:0]] <= mem_write_data;
    if (bd_we) bus_mem[bd_idx] <= bd_data;
  end

  always @(negedge clk) begin
    checks++;
    assert (!(mem_memread && mem_memwrite)) else begin
      errors++;
      $error("FAIL rw_exclusive: memread=%0b memwrite=%0b required not both", mem_memread, mem_memwrite);
    end
    if (mem_memread) begin
      n_rd++;
      last_addr = mem_addr;
      last_mask = mem_sign_mask;
    end
    if (mem_memwrite) begin
      n_wr++;
      last_addr  = mem_addr;
      last_mask  = mem_sign_mask;
      last_wdata = mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 4'(idx); bd_data = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag);
    int lanesz, lane, widx, lat, exp_lat, exp_rd, exp_wr;
    bit mis, err, seen;
    logic [31:0] ea, word, v, fmask, exp_rdata, new_word;
    logic [3:0]  base, exp_mask;

    lanesz = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis    = (addr % lanesz) != 0;
    err    = TRAP && mis;
    ea     = addr - (addr % lanesz);
    widx   = int'(ea / 4) % 16;
    lane   = int'(ea % 4);
    base   = (lanesz == 1) ? 4'b0001 : (lanesz == 2) ? 4'b0011 : 4'b1111;
    exp_mask = base << lane;
    word   = ref_mem[widx];
    exp_rdata = 32'h0;
    new_word  = word;
    if (err) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 0;
    end else if (!wr) begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0;
      if (lanesz == 4) v = word;
      else begin
        fmask = (32'h1 << (8 * lanesz)) - 1;
        v = (word >> (8 * lane)) & fmask;
        if (!uns && v[8 * lanesz - 1]) v = v | ~fmask;
      end
      exp_rdata = v;
    end else begin
      exp_lat = (lanesz == 4) ? 2 : 4;
      exp_rd  = (lanesz == 4) ? 0 : 1;
      exp_wr  = 1;
      for (int i = 0; i < lanesz; i++)
        new_word[8 * (lane + i) +: 8] = wd[8 * i +: 8];
      ref_mem[widx] = new_word;
    end

    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    n_rd = 0; n_wr = 0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1; seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid) begin seen = 1'b1; break; end
    end
    chk({tag, ".resp_seen"}, 32'(seen), 32'd1);
    last_resp = resp_rdata;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".err"}, 32'(resp_err), 32'(err));
    chk({tag, ".ready_b2b"}, 32'(req_ready), 32'd1);
    chk({tag, ".n_rd"}, 32'(n_rd), 32'(exp_rd));
    chk({tag, ".n_wr"}, 32'(n_wr), 32'(exp_wr));
    if (exp_rd + exp_wr > 0) begin
      chk({tag, ".mem_addr"}, last_addr, 32'(widx));
      chk({tag, ".mask"}, 32'(last_mask), 32'(exp_mask));
    end
    if (exp_wr > 0) begin
      chk({tag, ".wdata"}, last_wdata, new_word);
      chk({tag, ".mem"}, bus_mem[widx], ref_mem[widx]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr, uns;
    logic [1:0] sz;
    logic [31:0] a;

    #12;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.memread", 32'(mem_memread), 32'd0);
    chk("rst.memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mask", 32'(mem_sign_mask), 32'd0);
    chk("rst.wdata", mem_write_data, 32'h0);
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load at 0x10.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "st_w");
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld_w");
    chk("ld_w.const", last_resp, 32'hDEADBEEF);

    // Lane extraction from 0x11228344.
    preload(0, 32'h11228344);
    do_req(1'b0, 2'b00, 1'b0, 32'h01, 32'h0, "lb_s");
    chk("lb_s.const", last_resp, 32'hFFFFFF83);
    do_req(1'b0, 2'b00, 1'b1, 32'h01, 32'h0, "lb_u");
    chk("lb_u.const", last_resp, 32'h00000083);
    do_req(1'b0, 2'b01, 1'b0, 32'h02, 32'h0, "lh_s");
    chk("lh_s.const", last_resp, 32'h00001122);

    // Byte store into the top lane via read-modify-write.
    do_req(1'b1, 2'b00, 1'b0, 32'h03, 32'h000000AB, "sb_rmw");
    chk("sb_rmw.const", bus_mem[0], 32'hAB228344);
    chk("sb_rmw.mask_const", 32'(last_mask), 32'h8);

    // Misaligned half load and misaligned word store.
    do_req(1'b0, 2'b01, 1'b1, 32'h01, 32'h0, "lh_mis");
    do_req(1'b1, 2'b11, 1'b0, 32'h0E, 32'h12345678, "sw_mis");
    do_req(1'b1, 2'b01, 1'b0, 32'h06, 32'h0000C3D4, "sh");

    // Reset while in the merge step: no write, memory untouched.
    preload(2, 32'hCAFEF00D);
    @(negedge clk);
    n_rd = 0; n_wr = 0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h09; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort.rmw_read_seen", 32'(n_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.ready", 32'(req_ready), 32'd1);
    chk("abort.memwrite", 32'(mem_memwrite), 32'd0);
    chk("abort.resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort.n_wr", 32'(n_wr), 32'd0);
    chk("abort.mem", bus_mem[2], 32'hCAFEF00D);
    chk("abort.resp_valid_after", 32'(resp_valid), 32'd0);

    for (int t = 0; t < 150; t++) begin
      wr  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 63));
      do_req(wr, sz, uns, a, $urandom, "rnd");
    end

    for (int i = 0; i < 16; i++) chk("final.mem", bus_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
